// File: rtl/vga_timing_gen.sv
// 640x480 VGA timing generator (800x525 total) with registered syncs and a frame pulse/counter.
// Define VGA_SYNC_DELAY_EN to delay hs/vs/blank by two extra pixel-pipeline stages.
module vga_timing_gen (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] HS_FIRST = 10'd656;
  localparam logic [9:0] HS_LAST  = 10'd751;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] VS_FIRST = 10'd490;
  localparam logic [9:0] VS_LAST  = 10'd491;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};

  logic [9:0]  draw_x_q, draw_x_d;
  logic [9:0]  draw_y_q, draw_y_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  sync_t       sync_q, sync_d;
  logic        x_wrap, y_wrap;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    x_wrap        = (draw_x_q == H_LAST);
    y_wrap        = (draw_y_q == V_LAST);
    draw_x_d      = draw_x_q + 10'd1;
    draw_y_d      = draw_y_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (x_wrap) begin
      draw_x_d = '0;
      if (y_wrap) begin
        draw_y_d      = '0;
        frame_start_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 16'd1;
      end else begin
        draw_y_d = draw_y_q + 10'd1;
      end
    end
    // Decoded from the next-state counters so the registered syncs land on the same pixel.
    sync_d.hs    = !((draw_x_d >= HS_FIRST) && (draw_x_d <= HS_LAST));
    sync_d.vs    = !((draw_y_d >= VS_FIRST) && (draw_y_d <= VS_LAST));
    sync_d.blank = (draw_x_d < H_VIS) && (draw_y_d < V_VIS);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      sync_q        <= SYNC_RST;
    end else begin
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      sync_q        <= sync_d;
    end
  end

  assign DrawX       = draw_x_q;
  assign DrawY       = draw_y_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

`ifdef VGA_SYNC_DELAY_EN
  // Two stages matching the ROM-read + palette-register pixel pipeline.
  localparam sync_t DLY_RST = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  sync_t dly1_q, dly1_d;
  sync_t dly2_q, dly2_d;

  always_comb begin
    dly1_d = sync_q;
    dly2_d = dly1_q;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      dly1_q <= DLY_RST;
      dly2_q <= DLY_RST;
    end else begin
      dly1_q <= dly1_d;
      dly2_q <= dly2_d;
    end
  end

  assign hs    = dly2_q.hs;
  assign vs    = dly2_q.vs;
  assign blank = dly2_q.blank;
`else
  assign hs    = sync_q.hs;
  assign vs    = sync_q.vs;
  assign blank = sync_q.blank;
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have port: vga_clk  input  1  pixel clock, 25 MHz nominal, all logic on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL have port: DrawX  output  10  current horizontal pixel counter, 0..799.
REQ-004 SHALL have port: DrawY  output  10  current vertical line counter, 0..524.
REQ-005 SHALL have port: hs  output  1  horizontal sync, active-low.
REQ-006 SHALL have port: vs  output  1  vertical sync, active-low.
REQ-007 SHALL have port: blank  output  1  display-enable; 1 = visible pixel (renderers drive RGB only when 1).
REQ-008 SHALL have port: frame_start  output  1  one-cycle pulse at start of each new frame.
REQ-009 SHALL have port: frame_cnt  output  16  frames completed since reset, for animation/scroll.

Function
REQ-010 SHALL increment DrawX by 1 every vga_clk; at 799 SHALL wrap to 0 and increment DrawY.
REQ-011 SHALL wrap DrawY from 524 to 0 in the same cycle DrawX wraps from 799 (frame end).
REQ-012 SHALL keep DrawX, DrawY, hs, vs, blank all registered, mutually aligned to the same pixel; no combinational output paths.
REQ-013 SHALL drive hs=0 exactly when DrawX in 656..751 (96 clocks), else 1.
REQ-014 SHALL drive vs=0 exactly when DrawY in 490..491 (2 lines), else 1.
REQ-015 SHALL drive blank=1 exactly when DrawX<640 and DrawY<480, else 0.
REQ-016 SHALL compute hs/vs/blank from next-state counter values so they change on the same edge as DrawX/DrawY.
REQ-017 SHALL assert frame_start for exactly the one cycle with DrawX=0, DrawY=0 reached by wrap from (799,524); SHALL NOT assert it on the first cycle after reset.
REQ-018 SHALL increment frame_cnt on the wrap edge (same edge frame_start rises); 65535 wraps to 0.
REQ-019 SHALL use counter width 10 bits with explicit compares; no reliance on natural overflow for DrawX/DrawY.

Reset
REQ-020 SHALL, while reset_n=0, force DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_start=0, frame_cnt=0, immediately (asynchronous).
REQ-021 SHALL release reset synchronously-clean: first edge after reset_n rises advances DrawX to 1.
REQ-022 SHALL, on reset mid-frame, abandon the frame; no frame_start and no frame_cnt increment caused by the reset.

Configuration
REQ-023 SHALL support macro VGA_SYNC_DELAY_EN.
REQ-024 With VGA_SYNC_DELAY_EN defined, hs, vs and blank SHALL be delayed by 2 additional vga_clk stages (matching ROM-read + palette-register pixel pipeline); delay registers reset to hs=1, vs=1, blank=0; DrawX/DrawY/frame_start/frame_cnt undelayed.
REQ-025 Without VGA_SYNC_DELAY_EN, hs, vs, blank SHALL be aligned to DrawX/DrawY per REQ-012.

Verification
REQ-026 Reset release, run 800 clocks -> DrawX sequence 1..799,0; DrawY goes 0->1 on the 0; hs low for exactly 96 clocks starting DrawX=656.
REQ-027 Run one full frame (420000 clocks) -> vs low for exactly 1600 clocks starting at (0,490); frame_start pulses once at (0,0); frame_cnt=1.
REQ-028 Count blank=1 cycles over one frame -> exactly 307200; blank=0 at (640,0) and (0,480).
REQ-029 Assert reset_n=0 at (300,200) for 3 clocks -> outputs at reset values immediately; after release no frame_start until next natural wrap; frame_cnt stays 0.
REQ-030 Force frame_cnt near wrap (run 65536 frames or preload via backdoor 65535) -> next wrap gives frame_cnt=0 with frame_start=1.
REQ-031 With VGA_SYNC_DELAY_EN defined -> hs falls when DrawX=658, blank falls when DrawX=642; without it, at 656 and 640.
